// File: rtl/transaction_sequencer.sv
// Multi-step transaction sequencer: walks steps 1..NUM_STEPS, reports done/error pulses and counts successes.
// Optional per-step timeout is compiled in with macro TXN_STEP_TIMEOUT_EN.
module transaction_sequencer #(
   parameter int NUM_STEPS      = 4,
   parameter int STEP_W         = 3,
   parameter int COUNT_W        = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_STEPS-1:0] step_done,
   input  logic [NUM_STEPS-1:0] step_fail,
   output logic [STEP_W-1:0]    step,
   output logic                 step_start,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [1:0]           err_code,
   output logic [STEP_W-1:0]    err_step,
   output logic [COUNT_W-1:0]   txn_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_END  = 2'd2
   } state_t;

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS);

   state_t               state_q, state_d;
   logic [STEP_W-1:0]    step_q, step_d;
   logic                 step_start_q, step_start_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic [1:0]           err_code_q, err_code_d;
   logic [STEP_W-1:0]    err_step_q, err_step_d;
   logic [COUNT_W-1:0]   txn_count_q, txn_count_d;
   logic                 sampled_s;
   logic                 done_bit_s;
   logic                 fail_bit_s;
   logic                 timeout_s;

`ifdef TXN_STEP_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   assign timeout_s = sampled_s && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_s;

   assign timeout_s        = 1'b0;
   assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

   // The step inputs are ignored in the cycle that announces a new step.
   assign sampled_s = (state_q == S_RUN) && !step_start_q;

   // Select the handshake bits belonging to the active step.
   always_comb begin
      done_bit_s = 1'b0;
      fail_bit_s = 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) begin
         if (step_q == STEP_W'(i + 1)) begin
            done_bit_s = step_done[i];
            fail_bit_s = step_fail[i];
         end else begin
            done_bit_s = done_bit_s;
            fail_bit_s = fail_bit_s;
         end
      end
   end

   // Next-state and registered-output logic; priority abort > fail > timeout > done.
   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      step_start_d = 1'b0;
      done_d       = 1'b0;
      error_d      = 1'b0;
      err_code_d   = err_code_q;
      err_step_d   = err_step_q;
      txn_count_d  = txn_count_q;
`ifdef TXN_STEP_TIMEOUT_EN
      to_cnt_d     = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d      = S_RUN;
               step_d       = STEP_W'(1);
               step_start_d = 1'b1;
               err_code_d   = 2'd0;
               err_step_d   = STEP_W'(0);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (abort || (sampled_s && fail_bit_s) || timeout_s) begin
               state_d    = S_END;
               step_d     = STEP_W'(0);
               error_d    = 1'b1;
               err_step_d = step_q;
               if (abort) begin
                  err_code_d = 2'd3;
               end else if (sampled_s && fail_bit_s) begin
                  err_code_d = 2'd1;
               end else begin
                  err_code_d = 2'd2;
               end
            end else if (sampled_s && done_bit_s) begin
               if (step_q == LAST_STEP) begin
                  state_d = S_END;
                  step_d  = STEP_W'(0);
                  done_d  = 1'b1;
                  if (txn_count_q != {COUNT_W{1'b1}}) begin
                     txn_count_d = txn_count_q + COUNT_W'(1);
                  end else begin
                     txn_count_d = txn_count_q;
                  end
               end else begin
                  step_d       = step_q + STEP_W'(1);
                  step_start_d = 1'b1;
               end
            end else begin
`ifdef TXN_STEP_TIMEOUT_EN
               to_cnt_d = sampled_s ? (to_cnt_q + TO_W'(1)) : '0;
`endif
               state_d = S_RUN;
            end
         end
         S_END: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            step_d  = STEP_W'(0);
         end
      endcase
      busy_d = (step_d != STEP_W'(0));
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         step_q       <= '0;
         step_start_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_code_q   <= 2'd0;
         err_step_q   <= '0;
         txn_count_q  <= '0;
`ifdef TXN_STEP_TIMEOUT_EN
         to_cnt_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         step_start_q <= step_start_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         err_code_q   <= err_code_d;
         err_step_q   <= err_step_d;
         txn_count_q  <= txn_count_d;
`ifdef TXN_STEP_TIMEOUT_EN
         to_cnt_q     <= to_cnt_d;
`endif
      end
   end

   assign step       = step_q;
   assign step_start = step_start_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign err_code   = err_code_q;
   assign err_step   = err_step_q;
   assign txn_count  = txn_count_q;

endmodule
